// File: rtl/reg_mux_arb.sv
// reg_mux_arb: N-channel valid/ready multiplexer feeding a single output register.
// Mode 0 takes the channel named by sel. Mode 1 is a round-robin search that
// starts at ptr. The output register can pop and load on the same edge, so
// back-to-back transfers run at full rate with no bubble.
module reg_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_ch_q, out_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic              load_en;
  logic              grant;
  logic [SELW-1:0]   gnt_idx;
  logic              xfer;

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  // The register can take new data when it is empty or is being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection: direct select in mode 0, round-robin search from ptr in mode 1.
  always_comb begin
    int              idx;
    logic [SELW-1:0] cand;
    grant   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (!mode) begin
      if ((int'(sel) < N) && in_valid[sel]) begin
        grant   = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        cand = idx[SELW-1:0];
        if (!grant && in_valid[cand]) begin
          grant   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // A transfer needs a grant and room in the register. It is blocked while reset is held.
  assign xfer = grant && load_en && !rst;

  // Only the granted channel sees ready. All ready bits are low under backpressure or reset.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  // Output register next state: load on transfer, drop to EMPTY on pop without a grant.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      state_d    = FULL;
      out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_ch_d   = gnt_idx;
      if (int'(gnt_idx) == N - 1) ptr_d = '0;
      else                        ptr_d = gnt_idx + SELW'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State registers. Reset clears everything, including held data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_reg_mux_arb.sv
// Scoreboard bench for reg_mux_arb (N=4, WIDTH=32): directed scenarios plus random traffic.
module tb_reg_mux_arb;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SELW-1:0]    sel = '0;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SELW-1:0]    out_ch;

  reg_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
  } item_t;

  item_t         exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            m_valid = 1'b0;
  int            m_ptr = 0;
  logic [N-1:0]  exp_in_ready = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ch_data(input int c);
    return in_data[c*WIDTH +: WIDTH];
  endfunction

  // Reference model for one cycle. Inputs are already driven. It works out the grant
  // from the arbitration rules, records the expected result, and then crosses the edge.
  task automatic cycle();
    bit gr;
    int g;
    bit load;
    bit nv;
    load = !m_valid || out_ready;
    gr = 1'b0;
    g = 0;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) begin gr = 1'b1; g = int'(sel); end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!gr && in_valid[c]) begin gr = 1'b1; g = c; end
      end
    end
    exp_in_ready = (gr && load) ? N'(1 << g) : '0;
    if (gr && load) begin
      item_t it;
      it.ch = g;
      it.data = ch_data(g);
      exp_q.push_back(it);
      nv = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      nv = 1'b0;
    end else begin
      nv = m_valid;
    end
    @(posedge clk);
    #1;
    m_valid = nv;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    exp_in_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: checks handshakes against the scoreboard and holds during backpressure.
  bit               hold = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [SELW-1:0]  hold_ch;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
      if (hold) begin
        chk("hold_data", 64'(out_data), 64'(hold_data));
        chk("hold_ch", 64'(out_ch), 64'(hold_ch));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got ch %0d data %0h, expected no output", out_ch, out_data);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          chk("pop_data", 64'(out_data), 64'(it.data));
          chk("pop_ch", 64'(out_ch), 64'(it.ch));
        end
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_ch = out_ch;
    end
  end

  initial begin
    int rr_exp[5];
    int sp_exp[4];
    rr_exp = '{0, 1, 2, 3, 0};
    sp_exp = '{1, 3, 1, 3};

    // Reset state with every channel requesting.
    in_data = {32'd7, 32'd5, 32'd3, 32'd4};
    in_valid = 4'b1111;
    mode = 1'b0;
    sel = 2'd1;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    model_reset();

    // Direct select of channel 1 right after reset release.
    cycle();
    chk("rel_out_data", 64'(out_data), 64'd3);
    chk("rel_out_ch", 64'(out_ch), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'b0010);
    cycle();
    chk("rel2_out_valid", 64'(out_valid), 64'd1);

    // Round-robin with all channels requesting.
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_ch", 64'(out_ch), 64'(rr_exp[i]));
    end

    // Sparse round-robin requests.
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("sparse_ch", 64'(out_ch), 64'(sp_exp[i]));
    end

    // Backpressure while holding 5, then pop and load on the same edge.
    do_reset();
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    cycle();
    chk("bp_load", 64'(out_data), 64'd5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_data", 64'(out_data), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    sel = 2'd3;
    cycle();
    chk("bp_pop_load_data", 64'(out_data), 64'd7);
    chk("bp_pop_load_valid", 64'(out_valid), 64'd1);

    // Select points at a channel that is not requesting, then move to a requesting one.
    sel = 2'd1;
    in_valid = 4'b1101;
    cycle();
    chk("inv_sel_empty", 64'(out_valid), 64'd0);
    chk("inv_sel_hold", 64'(out_data), 64'd7);
    sel = 2'd2;
    cycle();
    chk("sel2_valid", 64'(out_valid), 64'd1);
    chk("sel2_ch", 64'(out_ch), 64'd2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) in_data[c*WIDTH +: WIDTH] = $urandom;
      in_valid = N'($urandom_range(0, 15));
      mode = 1'($urandom_range(0, 1));
      sel = SELW'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Reset asserted between edges while the register is full.
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b1111;
    in_data = {32'd7, 32'd5, 32'd3, 32'd4};
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("mid_full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_ch", 64'(out_ch), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    mode = 1'b1;
    in_valid = 4'b1100;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_ch", 64'(out_ch), 64'd2);
    chk("post_rst_data", 64'(out_data), 64'd5);

    // Drain the output so that every queued item gets compared.
    in_valid = '0;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
